aes_key_schedule: RTL and testbench

Parametrised iterative AES key expansion engine supporting AES-128/192/256, selected per request. Expands one 32-bit schedule word per clock into an internal round-key store. After expansion, the cipher datapath reads any round key through a registered read port. Successor to the fixed 128-bit round-key generator, adding key-length modes, a start/ready handshake, error reporting and random-access readout.

---
 rtl/aes_ks_pkg.sv | 71 +++++++
 rtl/aes_ks_word.sv | 42 ++++
 rtl/aes_key_schedule.sv | 201 ++++++++++++++++++++
 tb/tb_aes_key_schedule.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ks_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_ks_pkg
//  Description : Shared encodings, FSM state type, S-box table and helpers
//                for the AES key expansion engine.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_ks_pkg;

    // key_len encoding
    localparam logic [1:0] KEY_LEN_128  = 2'd0;
    localparam logic [1:0] KEY_LEN_192  = 2'd1;
    localparam logic [1:0] KEY_LEN_256  = 2'd2;
    localparam logic [1:0] KEY_LEN_RSVD = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DONE   = 2'd2
    } ks_state_e;

    // Forward AES S-box, entry 0 in the most significant byte
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        // entry x sits at byte position 255-x from the LSB end
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Key length in 32-bit words
    function automatic logic [3:0] nk_of(input logic [1:0] len);
        case (len)
            KEY_LEN_192: return 4'd6;
            KEY_LEN_256: return 4'd8;
            default:     return 4'd4;
        endcase
    endfunction

    // Number of rounds
    function automatic logic [3:0] nr_of(input logic [1:0] len);
        case (len)
            KEY_LEN_192: return 4'd12;
            KEY_LEN_256: return 4'd14;
            default:     return 4'd10;
        endcase
    endfunction

    // Index of the final schedule word, 4*(Nr+1)-1
    function automatic logic [5:0] last_word_of(input logic [1:0] len);
        case (len)
            KEY_LEN_192: return 6'd51;
            KEY_LEN_256: return 6'd59;
            default:     return 6'd43;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_ks_word.sv
`default_nettype none
// ============================================================================
//  Module      : aes_ks_word
//  Description : Combinational next-word function of the AES key schedule.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_ks_word
    import aes_ks_pkg::*;
(
    input  logic [31:0] w_prev_i,     // w[i-1]
    input  logic [31:0] w_old_i,      // w[i-Nk]
    input  logic        rot_sub_i,    // i mod Nk == 0
    input  logic        sub_only_i,   // Nk == 8 and i mod Nk == 4
    input  logic [7:0]  rcon_i,
    output logic [31:0] w_new_o
);

    logic [31:0] w_sub_in;
    logic [31:0] w_sub;
    logic [31:0] w_temp;

    // RotWord only applies on the Rcon step
    assign w_sub_in = rot_sub_i ? {w_prev_i[23:0], w_prev_i[31:24]} : w_prev_i;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        assign w_sub[8*b +: 8] = sbox(w_sub_in[8*b +: 8]);
    end

    // Select the transformed or plain previous word
    always_comb begin
        w_temp = w_prev_i;
        if (rot_sub_i) begin
            w_temp = w_sub ^ {rcon_i, 24'h000000};
        end else if (sub_only_i) begin
            w_temp = w_sub;
        end
    end

    assign w_new_o = w_temp ^ w_old_i;

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_schedule
//  Description : Iterative AES-128/192/256 key expansion, one schedule word
//                per clock, with a registered random-access round-key port.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_key_schedule
    import aes_ks_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic                    clk,
    input  logic                    rest_n,
    input  logic                    start,
    input  logic [1:0]              key_len,
    input  logic [MAX_KEY_BITS-1:0] key_in,
    output logic                    busy,
    output logic                    ready,
    output logic                    cfg_err,
    input  logic                    rd_en,
    input  logic [3:0]              rd_round,
    output logic [127:0]            rd_key,
    output logic                    rd_valid,
    output logic                    rd_err
);

    localparam int         MAX_NK     = MAX_KEY_BITS / 32;
    localparam int         MAX_ROUNDS = MAX_NK + 6;
    localparam int         T_MAX      = 4 * (MAX_ROUNDS + 1);
    localparam logic [3:0] MAX_NK4    = 4'(MAX_NK);

    ks_state_e   state_q, state_d;
    logic [3:0]  nk_q, nr_q;
    logic [5:0]  i_q, last_q;
    logic [2:0]  phase_q;
    logic [7:0]  rcon_q;
    logic        ready_q, cfg_err_q;
    logic [31:0] win_q   [MAX_NK];     // win_q[0] = w[i-Nk], win_q[Nk-1] = w[i-1]
    logic [31:0] store_q [T_MAX];
    logic [127:0] rd_key_q;
    logic        rd_valid_q, rd_err_q;

    logic [31:0] w_key [MAX_NK];
    logic [3:0]  w_nk_in;
    logic        w_key_ok, w_accept, w_reject, w_last;
    logic [3:0]  w_top_idx;
    logic [31:0] w_prev, w_new;
    logic        w_rd_ok;
    logic [5:0]  w_rd_base;

    for (genvar j = 0; j < MAX_NK; j++) begin : g_key
        assign w_key[j] = key_in[MAX_KEY_BITS-1-32*j -: 32];
    end

    assign w_nk_in   = nk_of(key_len);
    assign w_key_ok  = (key_len != KEY_LEN_RSVD) && (w_nk_in <= MAX_NK4);
    assign w_accept  = start && (state_q != S_EXPAND) && w_key_ok;
    assign w_reject  = start && (state_q != S_EXPAND) && !w_key_ok;
    assign w_last    = (state_q == S_EXPAND) && (i_q == last_q);
    assign w_top_idx = nk_q - 4'd1;

    // Pick w[i-1] from the variable-length window
    always_comb begin
        w_prev = win_q[0];
        for (int j = 0; j < MAX_NK; j++) begin
            if (4'(j) == w_top_idx) begin
                w_prev = win_q[j];
            end
        end
    end

    aes_ks_word u_word (
        .w_prev_i   (w_prev),
        .w_old_i    (win_q[0]),
        .rot_sub_i  (phase_q == 3'd0),
        .sub_only_i ((nk_q == 4'd8) && (phase_q == 3'd4)),
        .rcon_i     (rcon_q),
        .w_new_o    (w_new)
    );

    // State register
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    state_d = S_EXPAND;
                end else if (w_reject) begin
                    state_d = S_IDLE;
                end
            end
            S_EXPAND: begin
                if (w_last) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Expansion counters, Rcon and status flags
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            nk_q      <= 4'd4;
            nr_q      <= 4'd10;
            last_q    <= 6'd43;
            i_q       <= 6'd0;
            phase_q   <= 3'd0;
            rcon_q    <= 8'h01;
            ready_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else if (w_accept) begin
            nk_q      <= w_nk_in;
            nr_q      <= nr_of(key_len);
            last_q    <= last_word_of(key_len);
            i_q       <= {2'b00, w_nk_in};
            phase_q   <= 3'd0;
            rcon_q    <= 8'h01;
            ready_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else if (w_reject) begin
            ready_q   <= 1'b0;
            cfg_err_q <= 1'b1;
        end else if (state_q == S_EXPAND) begin
            i_q     <= i_q + 6'd1;
            // phase tracks i mod Nk by wrapping at Nk-1
            phase_q <= ({1'b0, phase_q} == w_top_idx) ? 3'd0 : phase_q + 3'd1;
            if (phase_q == 3'd0) begin
                rcon_q <= xtime(rcon_q);
            end
            if (w_last) begin
                ready_q <= 1'b1;
            end
        end
    end

    // Word store and sliding window; contents are guarded by ready
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int j = 0; j < MAX_NK; j++) begin
                if (4'(j) < w_nk_in) begin
                    store_q[j] <= w_key[j];
                    win_q[j]   <= w_key[j];
                end
            end
        end else if (state_q == S_EXPAND) begin
            store_q[i_q] <= w_new;
            for (int j = 0; j < MAX_NK - 1; j++) begin
                win_q[j] <= win_q[j+1];
            end
            for (int j = 0; j < MAX_NK; j++) begin
                if (4'(j) == w_top_idx) begin
                    win_q[j] <= w_new;
                end
            end
        end
    end

    assign w_rd_ok   = ready_q && (rd_round <= nr_q);
    assign w_rd_base = w_rd_ok ? {rd_round, 2'b00} : 6'd0;

    // Registered read port, evaluated against pre-edge ready
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            rd_key_q   <= 128'd0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                if (w_rd_ok) begin
                    rd_key_q <= {store_q[w_rd_base],         store_q[w_rd_base + 6'd1],
                                 store_q[w_rd_base + 6'd2],  store_q[w_rd_base + 6'd3]};
                    rd_err_q <= 1'b0;
                end else begin
                    rd_key_q <= 128'd0;
                    rd_err_q <= 1'b1;
                end
            end
        end
    end

    assign busy     = (state_q == S_EXPAND);
    assign ready    = ready_q;
    assign cfg_err  = cfg_err_q;
    assign rd_key   = rd_key_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_schedule
//  Description : Directed self-checking bench for aes_key_schedule using
//                FIPS-197 key expansion vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_key_schedule;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk = 1'b0;
    logic         rest_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'd0;
    logic [255:0] key_in = '0;
    logic         busy, ready, cfg_err, rd_valid, rd_err;
    logic         rd_en = 1'b0;
    logic [3:0]   rd_round = 4'd0;
    logic [127:0] rd_key;

    logic         start2 = 1'b0;
    logic [1:0]   key_len2 = 2'd0;
    logic [127:0] key_in2 = '0;
    logic         busy2, ready2, cfg_err2, rd_valid2, rd_err2;
    logic         rd_en2 = 1'b0;
    logic [3:0]   rd_round2 = 4'd0;
    logic [127:0] rd_key2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
        .clk(clk), .rest_n(rest_n), .start(start), .key_len(key_len), .key_in(key_in),
        .busy(busy), .ready(ready), .cfg_err(cfg_err), .rd_en(rd_en), .rd_round(rd_round),
        .rd_key(rd_key), .rd_valid(rd_valid), .rd_err(rd_err)
    );

    aes_key_schedule #(.MAX_KEY_BITS(128)) dut128 (
        .clk(clk), .rest_n(rest_n), .start(start2), .key_len(key_len2), .key_in(key_in2),
        .busy(busy2), .ready(ready2), .cfg_err(cfg_err2), .rd_en(rd_en2), .rd_round(rd_round2),
        .rd_key(rd_key2), .rd_valid(rd_valid2), .rd_err(rd_err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start an expansion and count edges after E0 until ready
    task automatic run_key(input logic [1:0] len, input logic [255:0] key, input int exp_lat, input string name);
        int lat;
        start = 1'b1; key_len = len; key_in = key;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        lat = 0;
        while (!ready && lat < 200) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat !== exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_after_done: got %b want 0", name, busy);
        end
    endtask

    task automatic do_read(input logic [3:0] r, output logic [127:0] k, output logic v, output logic e);
        rd_en = 1'b1; rd_round = r;
        tick();
        rd_en = 1'b0;
        k = rd_key; v = rd_valid; e = rd_err;
    endtask

    task automatic test_reset();
        logic [127:0] k; logic v, e;
        rest_n = 1'b0;
        tick(); tick();
        rest_n = 1'b1;
        tick();
        vectors++;
        if ({busy, ready, cfg_err, rd_valid, rd_err} !== 5'b0 || rd_key !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_state: got flags %b key %h want 00000 key 0",
                     {busy, ready, cfg_err, rd_valid, rd_err}, rd_key);
        end
        do_read(4'd0, k, v, e);
        vectors++;
        if ({v, e} !== 2'b11 || k !== 128'd0) begin
            miscompares++;
            $display("FAIL idle_read: got v/e %b key %h want 11 key 0", {v, e}, k);
        end
    endtask

    task automatic test_aes128();
        logic [127:0] k; logic v, e;
        run_key(2'd0, {K128, 128'd0}, 40, "aes128");
        do_read(4'd0, k, v, e);
        vectors++;
        if ({v, e} !== 2'b10 || k !== K128) begin
            miscompares++;
            $display("FAIL aes128_r0: got v/e %b key %h want 10 key %h", {v, e}, k, K128);
        end
        do_read(4'd1, k, v, e);
        vectors++;
        if ({v, e} !== 2'b10 || k !== R128_1) begin
            miscompares++;
            $display("FAIL aes128_r1: got v/e %b key %h want 10 key %h", {v, e}, k, R128_1);
        end
        do_read(4'd10, k, v, e);
        vectors++;
        if ({v, e} !== 2'b10 || k !== R128_10) begin
            miscompares++;
            $display("FAIL aes128_r10: got v/e %b key %h want 10 key %h", {v, e}, k, R128_10);
        end
        do_read(4'd11, k, v, e);
        vectors++;
        if ({v, e} !== 2'b11 || k !== 128'd0) begin
            miscompares++;
            $display("FAIL aes128_r11: got v/e %b key %h want 11 key 0", {v, e}, k);
        end
        tick();
        vectors++;
        if (rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_valid_pulse: got %b want 0", rd_valid);
        end
    endtask

    task automatic test_aes192();
        logic [127:0] k; logic v, e;
        run_key(2'd1, {K192, 64'd0}, 46, "aes192");
        do_read(4'd12, k, v, e);
        vectors++;
        if ({v, e} !== 2'b10 || k !== R192_12) begin
            miscompares++;
            $display("FAIL aes192_r12: got v/e %b key %h want 10 key %h", {v, e}, k, R192_12);
        end
        do_read(4'd13, k, v, e);
        vectors++;
        if ({v, e} !== 2'b11) begin
            miscompares++;
            $display("FAIL aes192_r13: got v/e %b want 11", {v, e});
        end
    endtask

    task automatic test_aes256();
        logic [127:0] k; logic v, e;
        run_key(2'd2, K256, 52, "aes256");
        do_read(4'd14, k, v, e);
        vectors++;
        if ({v, e} !== 2'b10 || k !== R256_14) begin
            miscompares++;
            $display("FAIL aes256_r14: got v/e %b key %h want 10 key %h", {v, e}, k, R256_14);
        end
    endtask

    task automatic test_cfg_err();
        logic [127:0] k; logic v, e;
        start = 1'b1; key_len = 2'd3;
        tick();
        start = 1'b0;
        vectors++;
        if ({cfg_err, ready, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL cfg_err_rsvd: got err/ready/busy %b want 100", {cfg_err, ready, busy});
        end
        do_read(4'd0, k, v, e);
        vectors++;
        if ({v, e} !== 2'b11) begin
            miscompares++;
            $display("FAIL read_after_reject: got v/e %b want 11", {v, e});
        end
    endtask

    task automatic test_max128();
        int lat;
        start2 = 1'b1; key_len2 = 2'd2; key_in2 = K128;
        tick();
        start2 = 1'b0;
        vectors++;
        if ({cfg_err2, busy2} !== 2'b10) begin
            miscompares++;
            $display("FAIL max128_len256: got err/busy %b want 10", {cfg_err2, busy2});
        end
        start2 = 1'b1; key_len2 = 2'd0;
        tick();
        start2 = 1'b0;
        lat = 0;
        while (!ready2 && lat < 200) begin
            tick();
            lat++;
        end
        rd_en2 = 1'b1; rd_round2 = 4'd10;
        tick();
        rd_en2 = 1'b0;
        vectors++;
        if (lat !== 40 || cfg_err2 !== 1'b0 || rd_key2 !== R128_10 || rd_err2 !== 1'b0) begin
            miscompares++;
            $display("FAIL max128_aes128: got lat %0d err %b key %h want 40 0 %h", lat, cfg_err2, rd_key2, R128_10);
        end
    endtask

    task automatic test_reset_abort();
        logic [127:0] k; logic v, e;
        start = 1'b1; key_len = 2'd2; key_in = K256;
        tick();
        start = 1'b0;
        repeat (20) tick();
        rest_n = 1'b0;
        #1;
        vectors++;
        if ({busy, ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL async_abort: got busy/ready %b want 00", {busy, ready});
        end
        #2;
        rest_n = 1'b1;
        tick();
        run_key(2'd0, {K128, 128'd0}, 40, "after_abort");
        do_read(4'd10, k, v, e);
        vectors++;
        if ({v, e} !== 2'b10 || k !== R128_10) begin
            miscompares++;
            $display("FAIL after_abort_r10: got v/e %b key %h want 10 key %h", {v, e}, k, R128_10);
        end
    endtask

    task automatic test_start_ignored();
        logic [127:0] k; logic v, e;
        int lat;
        start = 1'b1; key_len = 2'd0; key_in = {K128, 128'd0};
        tick();
        start = 1'b0;
        lat = 0;
        while (!ready && lat < 200) begin
            start = (lat == 10);
            if (lat == 10) begin
                key_len = 2'd2; key_in = K256;
            end
            rd_en = (lat == 15); rd_round = 4'd0;
            tick();
            lat++;
            if (lat == 16) begin
                vectors++;
                if ({rd_valid, rd_err} !== 2'b11) begin
                    miscompares++;
                    $display("FAIL read_during_expand: got v/e %b want 11", {rd_valid, rd_err});
                end
            end
        end
        start = 1'b0; rd_en = 1'b0;
        vectors++;
        if (lat !== 40) begin
            miscompares++;
            $display("FAIL start_ignored_latency: got %0d want 40", lat);
        end
        do_read(4'd10, k, v, e);
        vectors++;
        if (k !== R128_10) begin
            miscompares++;
            $display("FAIL start_ignored_r10: got %h want %h", k, R128_10);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k; logic v, e;
        int lat;
        start = 1'b1; key_len = 2'd2; key_in = K256;
        rd_en = 1'b1; rd_round = 4'd0;
        tick();
        start = 1'b0; rd_en = 1'b0;
        vectors++;
        if ({rd_valid, rd_err} !== 2'b10 || rd_key !== K128) begin
            miscompares++;
            $display("FAIL rekey_old_r0: got v/e %b key %h want 10 key %h", {rd_valid, rd_err}, rd_key, K128);
        end
        do_read(4'd0, k, v, e);
        vectors++;
        if ({v, e} !== 2'b11 || k !== 128'd0) begin
            miscompares++;
            $display("FAIL rekey_read_busy: got v/e %b key %h want 11 key 0", {v, e}, k);
        end
        lat = 1;
        while (!ready && lat < 200) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat !== 52) begin
            miscompares++;
            $display("FAIL rekey_latency: got %0d want 52", lat);
        end
        do_read(4'd14, k, v, e);
        vectors++;
        if ({v, e} !== 2'b10 || k !== R256_14) begin
            miscompares++;
            $display("FAIL rekey_r14: got v/e %b key %h want 10 key %h", {v, e}, k, R256_14);
        end
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_cfg_err();
        test_max128();
        test_reset_abort();
        test_start_ignored();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
